// File: rtl/rr_code_encoder.sv
// ---------------------------------------------------------------------------
// rr_code_encoder
//
// Purpose:
//   Upstream stage of the 3-to-8 select decoder. Collects 8 request lines
//   into a sticky pending register. It picks one outstanding request at a
//   time with round-robin arbitration. The winner is offered as a registered
//   3-bit code over a valid/ready handshake. code_out is held constant while
//   it is offered, so the decoder it drives never glitches mid-transfer.
//
// Ports:
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   req       in   REQ_W  request pulses/levels, bit i requests code i
//   ready     in   1      downstream accepts code_out this cycle
//   code_out  out  CODE_W granted code (registered)
//   valid     out  1      code_out is being offered
//   pending   out  REQ_W  latched outstanding requests
//   idle      out  1      IDLE state with nothing pending
//   cnt_clr   in   1      (RR_CODE_ENCODER_STATS_EN only) zero grant_cnt
//   grant_cnt out  8      (RR_CODE_ENCODER_STATS_EN only) saturating count
//                         of completed handshakes
//
// Optional feature:
//   Define RR_CODE_ENCODER_STATS_EN to add the grant counter and its clear.
// ---------------------------------------------------------------------------
module rr_code_encoder #(
    parameter int REQ_W  = 8,
    parameter int CODE_W = $clog2(REQ_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REQ_W-1:0]  req,
    input  logic              ready,
`ifdef RR_CODE_ENCODER_STATS_EN
    input  logic              cnt_clr,
    output logic [7:0]        grant_cnt,
`endif
    output logic [CODE_W-1:0] code_out,
    output logic              valid,
    output logic [REQ_W-1:0]  pending,
    output logic              idle
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    logic [0:0]        state;
    logic [CODE_W-1:0] rr_ptr;
    logic              handshake;
    logic [REQ_W-1:0]  clr_mask;
    logic [REQ_W-1:0]  pending_next;
    logic [CODE_W-1:0] winner;
    logic              found;
    logic [CODE_W-1:0] idx;

    // valid comes straight from the state register, so it is glitch-free.
    assign valid     = (state == ST_OFFER);
    assign handshake = valid & ready;
    assign idle      = (state == ST_IDLE) && (pending == '0);

    // A completed grant clears its bit. OR-ing req in afterwards means a
    // fresh request on the same edge keeps the bit set.
    assign clr_mask     = handshake ? (REQ_W'(1) << code_out) : '0;
    assign pending_next = (pending & ~clr_mask) | req;

    // Round-robin search: the first set pending bit starting at rr_ptr.
    // The 3-bit index wraps naturally from 7 back to 0.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < REQ_W; i++) begin
            idx = rr_ptr + CODE_W'(i);
            if (!found && pending[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Request capture runs every edge, regardless of FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Two-state offer FSM. Arbitration uses the registered pending value.
    // A raw req therefore takes one edge to be captured, and one more edge
    // to be offered. code_out only loads on entry to OFFER.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            code_out <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        code_out <= winner;
                        state    <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (ready) begin
                        rr_ptr <= code_out + CODE_W'(1);
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RR_CODE_ENCODER_STATS_EN
    // Saturating handshake counter. A clear on the same edge as an
    // increment wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else if (cnt_clr) begin
            grant_cnt <= '0;
        end else if (handshake && (grant_cnt != 8'hFF)) begin
            grant_cnt <= grant_cnt + 8'd1;
        end
    end
`endif

endmodule
